// File: rtl/v_calc_seq.sv
`default_nettype none
// ============================================================================
// Module      : v_calc_seq
// Description : Sequential calculator. Synchronises and edge-detects five
//               push-buttons, latches operands A/B, performs add, absolute
//               difference and multiply in one cycle, and divide/modulo over
//               W cycles using a restoring divider. The registered result is
//               saturated to DMAX for the 4-digit seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module v_calc_seq #(
    parameter int W    = 7,
    parameter int RW   = 14,
    parameter int DMAX = 9999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W:0]    sw,
    input  logic [4:0]    btn,
    output logic [RW-1:0] result,
    output logic [W-1:0]  rem,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int              c_CW       = $clog2(W + 1);
    localparam logic [1:0]      c_IDLE     = 2'd0;
    localparam logic [1:0]      c_DIV      = 2'd1;
    localparam logic [1:0]      c_DONE     = 2'd2;
    localparam logic [RW-1:0]   c_DMAX     = RW'(DMAX);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(W);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(1);

    // Button synchroniser and previous-value registers
    logic [4:0] s1_q, s1_d;
    logic [4:0] s2_q, s2_d;
    logic [4:0] p_q,  p_d;

    // Operand, divider and output registers
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    dq_q, dq_d;      // dividend shifting out, quotient shifting in
    logic [W-1:0]    dr_q, dr_d;      // partial remainder
    logic [W-1:0]    dd_q, dd_d;      // divisor snapshot
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [1:0]      state_q, state_d;
    logic [RW-1:0]   result_q, result_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Combinational helpers
    logic [4:0]     w_edge;
    logic [4:0]     w_sel;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_diff;
    logic [2*W-1:0] w_prod;
    logic [RW-1:0]  w_op_val;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W-1:0]   w_sub;

    // Button path: two-stage synchroniser followed by previous-value register
    always_comb begin
        s1_d = btn;
        s2_d = s1_q;
        p_d  = s2_q;
    end

    // Rising-edge detect; keep only the lowest-index edge when several coincide
    always_comb begin
        w_edge = s2_q & ~p_q;
        w_sel  = w_edge & (~w_edge + 5'd1);
    end

    // Single-cycle arithmetic, zero-extended to the result width
    always_comb begin
        w_sum    = {1'b0, a_q} + {1'b0, b_q};
        w_diff   = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
        w_prod   = (2*W)'(a_q) * (2*W)'(b_q);
        w_op_val = '0;
        if (w_sel[1]) begin
            w_op_val = RW'(w_sum);
        end else if (w_sel[2]) begin
            w_op_val = RW'(w_diff);
        end else if (w_sel[3]) begin
            w_op_val = RW'(w_prod);
        end
    end

    // One restoring shift-subtract step; the difference is taken modulo 2^W
    // since it is only kept when it is smaller than the divisor
    always_comb begin
        w_shift = {dr_q, dq_q[W-1]};
        w_ge    = (w_shift >= {1'b0, dd_q});
        w_sub   = w_shift[W-1:0] - dd_q;
    end

    // Control FSM: operand loads, single-cycle ops and divider sequencing
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        dq_d     = dq_q;
        dr_d     = dr_q;
        dd_d     = dd_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (w_sel[0]) begin
                    if (sw[W]) begin
                        b_d = sw[W-1:0];
                    end else begin
                        a_d = sw[W-1:0];
                    end
                end else if (w_sel[1] || w_sel[2] || w_sel[3]) begin
                    rem_d  = '0;
                    done_d = 1'b1;
                    if (w_op_val > c_DMAX) begin
                        result_d = c_DMAX;
                        err_d    = 1'b1;
                    end else begin
                        result_d = w_op_val;
                        err_d    = 1'b0;
                    end
                end else if (w_sel[4]) begin
                    if (b_q == '0) begin
                        result_d = '0;
                        rem_d    = '0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        dq_d    = a_q;
                        dr_d    = '0;
                        dd_d    = b_q;
                        cnt_d   = c_CNT_INIT;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = c_DIV;
                    end
                end
            end
            c_DIV: begin
                dr_d  = w_ge ? w_sub : w_shift[W-1:0];
                dq_d  = {dq_q[W-2:0], w_ge};
                cnt_d = cnt_q - c_CNT_LAST;
                if (cnt_q == c_CNT_LAST) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                result_d = RW'(dq_q);
                rem_d    = dr_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            p_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dq_q     <= '0;
            dr_q     <= '0;
            dd_q     <= '0;
            cnt_q    <= '0;
            state_q  <= c_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            p_q      <= p_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dq_q     <= dq_d;
            dr_q     <= dr_d;
            dd_q     <= dd_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign rem    = rem_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_v_calc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_v_calc_seq
// Description : Scoreboard testbench for v_calc_seq. Stimulus pushes the
//               expected result/rem/err into a queue; a monitor pops and
//               compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v_calc_seq;

    localparam int W  = 7;
    localparam int RW = 14;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [W-1:0]  m;
        logic          e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W:0]    sw  = '0;
    logic [4:0]    btn = '0;
    logic [RW-1:0] result;
    logic [W-1:0]  rem;
    logic          busy;
    logic          done;
    logic          err;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    exp_t mon_e;

    v_calc_seq #(.W(W), .RW(RW), .DMAX(9999)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .btn    (btn),
        .result (result),
        .rem    (rem),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done result=%0d required=no done", result);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_result", int'(result), int'(mon_e.r));
                chk("sb_rem",    int'(rem),    int'(mon_e.m));
                chk("sb_err",    int'(err),    int'(mon_e.e));
            end
        end
    end

    task automatic push(input int r, input int m, input int e);
        sbq.push_back(exp_t'{r: RW'(r), m: W'(m), e: e[0]});
    endtask

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        btn = b;
        repeat (4) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic tgt, input int v);
        sw = {tgt, W'(v)};
        press(5'b00001);
    endtask

    task automatic op(input int idx, input int r, input int m, input int e);
        logic [4:0] b;
        b = '0;
        b[idx] = 1'b1;
        push(r, m, e);
        press(b);
    endtask

    task automatic wait_busy(input string nm);
        for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
        chk(nm, int'(busy), 1);
    endtask

    initial begin
        int n;
        int seen;

        // Reset with every button held
        rst = 1'b1;
        btn = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_rem",    int'(rem),    0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_err",    int'(err),    0);
        @(negedge clk);
        btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Operands are zero after reset
        op(1, 0, 0, 0);

        load(1'b0, 100);
        load(1'b1, 27);

        // Add with latency check: press before edge k, done visible after k+2
        push(127, 0, 0);
        @(negedge clk);
        btn = 5'b00010;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("add_done_early", int'(done), 0);
        @(posedge clk);
        #1;
        chk("add_done_at_T", int'(done), 1);
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);

        op(2, 73, 0, 0);
        op(3, 2700, 0, 0);

        // Saturation then recovery
        load(1'b0, 127);
        load(1'b1, 127);
        op(3, 9999, 0, 1);
        op(1, 254, 0, 0);

        // Division 100 / 7 with ignored presses while busy
        load(1'b0, 100);
        load(1'b1, 7);
        push(14, 2, 0);
        @(negedge clk);
        btn = 5'b10000;
        wait_busy("div_busy_start");
        btn = '0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            if (n == 2) begin
                sw  = {1'b1, 7'd50};
                btn = 5'b00011;
            end
            if (n == 5) btn = '0;
        end
        btn = '0;
        chk("div_busy_cycles", n, 8);
        repeat (4) @(negedge clk);
        op(1, 107, 0, 0);

        // Divide by zero
        load(1'b1, 0);
        push(0, 0, 1);
        @(negedge clk);
        btn = 5'b10000;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1;
        end
        btn = '0;
        repeat (4) @(negedge clk);
        chk("div0_busy_seen", seen, 0);

        // Load leaves err untouched; simultaneous add+mul takes add
        load(1'b1, 7);
        chk("err_hold_load", int'(err), 1);
        push(107, 0, 0);
        press(5'b01010);

        // Reset on the third busy cycle of a division
        @(negedge clk);
        btn = 5'b10000;
        wait_busy("abort_busy_start");
        btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",   int'(busy),   0);
        chk("abort_result", int'(result), 0);
        chk("abort_rem",    int'(rem),    0);
        chk("abort_err",    int'(err),    0);
        chk("abort_done",   int'(done),   0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
